// File: rtl/rr_decoder_arbiter.sv
// Four-requester round-robin arbiter driving a 2-to-4 select decoder (index + enable) with a registered one-hot grant.
// Optional hold-timeout enabled by defining ARB_TIMEOUT_EN.
module rr_decoder_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [1:0]       last_idx;
    logic [CNT_W-1:0] hold_cnt;

    logic [3:0] owner_onehot;
    logic [3:0] cand_mask;
    logic       win_vld;
    logic [1:0] win_idx;

    // In BUSY the owner's bit is excluded: on release it is already low,
    // on a forced end it must not win its own re-arbitration.
    always_comb begin
        owner_onehot = 4'b0001 << gnt_idx;
        cand_mask    = (state == BUSY) ? (req & ~owner_onehot) : req;
        win_vld      = 1'b0;
        win_idx      = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (!win_vld && cand_mask[last_idx + 2'(i + 1)]) begin
                win_vld = 1'b1;
                win_idx = last_idx + 2'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            gnt_idx  <= 2'b00;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            last_idx <= 2'b11;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state    <= BUSY;
                        gnt      <= 4'b0001 << win_idx;
                        gnt_idx  <= win_idx;
                        gnt_vld  <= 1'b1;
                        last_idx <= win_idx;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!req[gnt_idx]) begin
                        hold_cnt <= '0;
                        if (win_vld) begin
                            gnt      <= 4'b0001 << win_idx;
                            gnt_idx  <= win_idx;
                            last_idx <= win_idx;
                        end else begin
                            state   <= IDLE;
                            gnt     <= 4'b0000;
                            gnt_idx <= 2'b00;
                            gnt_vld <= 1'b0;
                        end
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_cnt == HOLD_LAST) begin
                        // Forced end: hand over if anyone else waits, otherwise
                        // the owner restarts a fresh ownership.
                        timeout  <= 1'b1;
                        hold_cnt <= '0;
                        if (win_vld) begin
                            gnt      <= 4'b0001 << win_idx;
                            gnt_idx  <= win_idx;
                            last_idx <= win_idx;
                        end else begin
                            last_idx <= gnt_idx;
                        end
`endif
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
